// File: rtl/sextium_ram_pkg.sv
// Shared definitions for the sextium RAM arbiter.
//   ADDR_W / DATA_W : default word-address and data widths
//   port_idx_t      : index of a requester port
//   PORT_CPU        : s0, the CPU data port
//   PORT_DMA        : s1, the DMA/video port
package sextium_ram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef logic port_idx_t;

  localparam port_idx_t PORT_CPU = 1'b0;
  localparam port_idx_t PORT_DMA = 1'b1;

endpackage

// File: rtl/sextium_ram_arbiter_if.sv
// Avalon-MM requester link between one master and the arbiter.
//   master modport : requester side (drives address/byteenable/read/write/writedata)
//   slave modport  : arbiter side (drives readdata/waitrequest/readdatavalid)
//
// Handshake: a request is (read | write). It is accepted on a rising clk edge
// where the request is high and waitrequest is low; the master must hold all
// request signals stable while waitrequest is high. A waitrequest of 1 on an
// idle link carries no meaning. An accepted read returns exactly one
// readdatavalid pulse, on the cycle after acceptance; readdata is only
// meaningful while readdatavalid is 1.
interface sextium_ram_arbiter_if #(
  parameter int ADDR_W = sextium_ram_pkg::ADDR_W,
  parameter int DATA_W = sextium_ram_pkg::DATA_W
);

  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, waitrequest, readdatavalid
  );

endinterface

// File: rtl/sextium_rr_arb2.sv
// Two-way grant logic for the sextium RAM arbiter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : grants allowed this cycle
//   req[1:0]    : request per port (bit 0 = CPU, bit 1 = DMA)
//   gnt[1:0]    : one-hot (or zero) combinational grant
//   last_grant  : port that received the most recent grant (state register)
// Build option SEXTIUM_ARB_FIXED_PRIO_EN: CPU has strict priority and a
// starvation counter forces a DMA grant after MAX_WAIT refused cycles.
// Without it, ties alternate using last_grant.
module sextium_rr_arb2 import sextium_ram_pkg::*; #(
`ifdef SEXTIUM_ARB_FIXED_PRIO_EN
  parameter int MAX_WAIT = 8
`endif
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_idx_t last_grant
);

  port_idx_t last_grant_q, last_grant_d;

`ifdef SEXTIUM_ARB_FIXED_PRIO_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait1_q, wait1_d;

  always_comb begin
    gnt     = 2'b00;
    wait1_d = '0;
    if (en) begin
      if (req[1] && (!req[0] || wait1_q == WAIT_MAX)) gnt = 2'b10;
      else if (req[0])                               gnt = 2'b01;
    end
    // Counts refused DMA cycles; saturates so a long clken gap cannot wrap it.
    if (req[1] && !gnt[1]) begin
      wait1_d = (wait1_q == WAIT_MAX) ? wait1_q : wait1_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait1_q <= '0;
    else        wait1_q <= wait1_d;
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // On a tie the port that did not win last time goes first.
      if (req == 2'b11) gnt = (last_grant_q == PORT_DMA) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end
`endif

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[0])      last_grant_d = PORT_CPU;
    else if (gnt[1]) last_grant_d = PORT_DMA;
  end

  // Reset to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= PORT_DMA;
    else        last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/sextium_ram_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between two
// Avalon-MM requesters: s0 (CPU data) and s1 (DMA/video).
//   clk, reset      : clock, asynchronous active-low reset
//   clken           : global clock enable
//   reset_req       : hold-off; stops RAM clocking and new grants
//   s0, s1          : requester links (slave modport)
//   mem_*           : RAM pins (address, byteena, clock, clocken, data, wren, q)
//   dbg_last_grant  : arbiter last-grant state, for observation only
// Build option SEXTIUM_ARB_FIXED_PRIO_EN selects fixed CPU priority with a
// MAX_WAIT starvation bound instead of round-robin.
module sextium_ram_arbiter import sextium_ram_pkg::*; #(
  parameter int ADDR_W = sextium_ram_pkg::ADDR_W,
  parameter int DATA_W = sextium_ram_pkg::DATA_W
`ifdef SEXTIUM_ARB_FIXED_PRIO_EN
  ,
  parameter int MAX_WAIT = 8
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  sextium_ram_arbiter_if.slave s0,
  sextium_ram_arbiter_if.slave s1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteena,
  output logic                mem_clock,
  output logic                mem_clocken,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_q,
  output port_idx_t           dbg_last_grant
);

  localparam int BE_W = DATA_W / 8;

  logic              en;
  logic              arb_en;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_pend_q, rd_pend_d;
  port_idx_t         rd_port_q, rd_port_d;

  assign en = clken & ~reset_req;
  // Grants are also suppressed while reset is held so every output shows its
  // reset value even if requesters keep their lines up.
  assign arb_en = en & reset;
  assign req = {s1.read | s1.write, s0.read | s0.write};

`ifdef SEXTIUM_ARB_FIXED_PRIO_EN
  sextium_rr_arb2 #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clk(clk), .rst_n(reset), .en(arb_en), .req(req), .gnt(gnt),
    .last_grant(dbg_last_grant)
  );
`else
  sextium_rr_arb2 u_arb (
    .clk(clk), .rst_n(reset), .en(arb_en), .req(req), .gnt(gnt),
    .last_grant(dbg_last_grant)
  );
`endif

  // Bus mux: follows the granted port, otherwise holds the last granted values.
  // A read+write on one port is treated as a write and gets no read return.
  always_comb begin
    addr_d    = addr_q;
    be_d      = be_q;
    data_d    = data_q;
    mem_wren  = 1'b0;
    rd_pend_d = 1'b0;
    rd_port_d = rd_port_q;
    if (gnt[0]) begin
      addr_d    = s0.address;
      be_d      = s0.byteenable;
      data_d    = s0.writedata;
      mem_wren  = s0.write;
      rd_pend_d = s0.read & ~s0.write;
      if (rd_pend_d) rd_port_d = PORT_CPU;
    end else if (gnt[1]) begin
      addr_d    = s1.address;
      be_d      = s1.byteenable;
      data_d    = s1.writedata;
      mem_wren  = s1.write;
      rd_pend_d = s1.read & ~s1.write;
      if (rd_pend_d) rd_port_d = PORT_DMA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      be_q      <= '0;
      data_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_CPU;
    end else begin
      addr_q    <= addr_d;
      be_q      <= be_d;
      data_q    <= data_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  assign mem_address = addr_d;
  assign mem_byteena = be_d;
  assign mem_data    = data_d;
  assign mem_clock   = clk;
  assign mem_clocken = en;

  // The RAM latched a pending read before any clocken drop, so the return
  // strobe is not gated by en.
  assign s0.waitrequest   = ~gnt[0];
  assign s1.waitrequest   = ~gnt[1];
  assign s0.readdatavalid = rd_pend_q & (rd_port_q == PORT_CPU);
  assign s1.readdatavalid = rd_pend_q & (rd_port_q == PORT_DMA);
  assign s0.readdata      = mem_q;
  assign s1.readdata      = mem_q;

endmodule

// File: doc/sextium_ram_arbiter.md
Name: sextium_ram_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency, byte-enabled writes) between two Avalon-MM requesters: s0 is the CPU data port, s1 is the DMA/video port.
- Sits between the interconnect and the RAM's mem_* pins.
- Grants at most one access per cycle, round-robin, using waitrequest.
- Returns read data with a per-port readdatavalid one cycle after the grant.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 16, data width; byteenable width is DATA_W/8.
- MAX_WAIT, 8, starvation bound in cycles; used only with SEXTIUM_ARB_FIXED_PRIO_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clken  in  1  global clock enable.
- reset_req  in  1  reset-request hold-off; blocks RAM clocking and new grants.
- s0_address, s1_address  in  ADDR_W  requester word address.
- s0_byteenable, s1_byteenable  in  DATA_W/8  byte lanes for writes.
- s0_read, s1_read  in  1  read request.
- s0_write, s1_write  in  1  write request.
- s0_writedata, s1_writedata  in  DATA_W  write data.
- s0_readdata, s1_readdata  out  DATA_W  read data, qualified by readdatavalid.
- s0_waitrequest, s1_waitrequest  out  1  high = request not accepted this cycle.
- s0_readdatavalid, s1_readdatavalid  out  1  one-cycle read-return strobe.
- mem_address  out  ADDR_W  RAM address.
- mem_byteena  out  DATA_W/8  RAM byte enables.
- mem_clock  out  1  equals clk.
- mem_clocken  out  1  clken & ~reset_req.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data.

Behaviour:
- Request definitions: req_i = s_i_read | s_i_write. en = clken & ~reset_req.
- No grants while en = 0; both waitrequest stay high.
- Grant is combinational in the request cycle.
  - Only one port requesting: grant it.
  - Both requesting: grant the port other than last_grant.
  - last_grant register updates on every grant.
- Granted port: waitrequest = 0 in that cycle. Non-granted requesting port: waitrequest = 1.
- Idle port: waitrequest = 1 (Avalon-legal, because it is not requesting).
- Mux: mem_address, mem_byteena and mem_data follow the granted port. With no grant they hold the last granted values.
- mem_wren = grant & s_g_write.
- Read and write asserted together on one port is illegal. Treat it as a write; no readdatavalid is returned.
- Read return:
  - A granted read sets the registers rd_pend = 1 and rd_port = granted port at the clock edge.
  - Next cycle: s_{rd_port}_readdatavalid = 1 and s_{rd_port}_readdata = mem_q.
  - The other port's readdatavalid is 0.
  - Back-to-back reads pipeline with no bubble; throughput is 1 access per cycle.
- readdata for both ports is driven from mem_q at all times; it is meaningful only while readdatavalid = 1.
- A write at cycle t followed by a read of the same address at t+1 returns the new data (ordinary RAM behaviour; no bypass is required).
- Reset values: last_grant = 1, so s0 wins the first tie. rd_pend = 0, rd_port = 0, both readdatavalid = 0, both waitrequest = 1, mem_wren = 0, mem address/data/byteena registers = 0.
- Reset asserted mid-read: the pending read is discarded and no readdatavalid follows.
- reset_req asserted while rd_pend = 1: the read still returns next cycle, because the RAM latched it before clocken dropped.

Optional Feature:
- Macro: SEXTIUM_ARB_FIXED_PRIO_EN.
- Defined:
  - s0 has strict priority.
  - Counter wait1 increments each cycle s1 requests and is not granted; it resets on an s1 grant or when s1 is not requesting.
  - When wait1 reaches MAX_WAIT, s1 gets the next grant regardless of s0.
  - last_grant is unused.
- Undefined: plain round-robin as above; no counter is synthesised.

Decomposition:
- Package sextium_ram_pkg holds:
  - ADDR_W and DATA_W defaults;
  - port-index constants PORT_CPU = 0 and PORT_DMA = 1;
  - a typedef for the port index.
- One natural sub-module: sextium_rr_arb2, the 2-way grant logic (round-robin / fixed-priority with starvation counter), with req[1:0] in and gnt[1:0] plus last-grant state out.

Test Plan:
- Reset release, s0 reads address 0x0010 (RAM word = 0xBEEF) → s0_waitrequest = 0 in the same cycle; s0_readdatavalid = 1 with s0_readdata = 0xBEEF one cycle later; s1_readdatavalid = 0.
- s0 and s1 both read continuously for 6 cycles → grants alternate s0, s1, s0, …; each readdatavalid pulses on alternate cycles with the correct data.
- s1 writes 0x1234 to 0x0020 with byteenable = 2'b01, then reads it back → mem_wren = 1 for one cycle; readback = old upper byte : 0x34.
- clken = 0 for 3 cycles while s0 requests → s0_waitrequest held at 1 and mem_wren = 0; grant occurs in the first cycle after clken returns to 1.
- Assert reset for one cycle right after a granted s1 read → no s1_readdatavalid; all outputs at reset values.
- With SEXTIUM_ARB_FIXED_PRIO_EN and MAX_WAIT = 4, s0 and s1 request continuously → s1 is granted exactly once every 5 cycles; s0 receives all other grants.
